alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- ID/EX stage that sits directly upstream of the ALU and drives its iDataA, iDataB and iAluOp inputs.
- Registers decoded instructions and resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and inserts exactly one bubble for each.
- Supports valid/ready backpressure from EX and a flush from branch resolution (the ALU oZero path).

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width
OP_W, 4, ALU opcode width (matches the ALU encoding: ADD=0000, SUB=1000, ...)

Ports:
iClk  in  1  clock; all state updates on the rising edge
iRstN  in  1  reset; one clock; reset is asynchronous and active-low
iFlush  in  1  kill the held entry and the incoming instruction
iValid  in  1  decode presents an instruction
oReady  out  1  stage accepts the instruction this cycle
iRs1Addr  in  RA_W  source register 1 address
iRs2Addr  in  RA_W  source register 2 address
iRs1Data  in  XLEN  register-file read data for rs1
iRs2Data  in  XLEN  register-file read data for rs2
iImm  in  XLEN  sign-extended immediate
iUseImm  in  1  operand B is iImm instead of rs2
iAluOp  in  OP_W  ALU operation code
iRdAddr  in  RA_W  destination register address
iRegWrite  in  1  instruction writes rd
iIsLoad  in  1  instruction is a load
iMemRdAddr  in  RA_W  MEM-stage destination register
iMemRegWrite  in  1  MEM-stage instruction writes rd
iMemData  in  XLEN  MEM-stage final result, including load data
iWbRdAddr  in  RA_W  WB-stage destination register
iWbRegWrite  in  1  WB-stage instruction writes rd
iWbData  in  XLEN  WB-stage write data
oValid  out  1  entry valid toward EX
iReady  in  1  EX accepts the entry
oDataA  out  XLEN  ALU operand A
oDataB  out  XLEN  ALU operand B
oStoreData  out  XLEN  forwarded rs2 value, always rs2 even when iUseImm=1
oAluOp  out  OP_W  ALU opcode
oRdAddr  out  RA_W  destination register
oRegWrite  out  1  write enable for rd
oIsLoad  out  1  entry is a load

Behaviour:
- Reset: all outputs 0; state EMPTY; oReady=1 (combinational).
- FSM states:
  - EMPTY: no entry held.
  - FULL: entry held with oValid=1.
  - BUBBLE: one cycle with oValid=0 after a load-use hazard.
- Fire conditions: fire_in = iValid & oReady; fire_out = oValid & iReady.
- Load-use hazard (lu):
  - Condition: oValid & oIsLoad & oRegWrite & (oRdAddr != 0) & iValid & (oRdAddr == iRs1Addr | (oRdAddr == iRs2Addr & ~iUseImm) | (oRdAddr == iRs2Addr & store)).
  - Store is indicated by the opcode-independent term (~iRegWrite & ~iUseImm == 0) — simplified: any rs2 match counts.
- oReady = ~lu & (~oValid | iReady).
- Transitions:
  - EMPTY --fire_in--> FULL.
  - FULL --fire_out & fire_in--> FULL (new entry loaded).
  - FULL --fire_out & ~fire_in & ~lu--> EMPTY.
  - FULL --fire_out & lu--> BUBBLE (oValid=0 for 1 cycle; incoming held by decode).
  - BUBBLE --> EMPTY, or FULL if fire_in.
  - FULL & ~iReady: every output register holds its value.
- Forwarding, per source operand, evaluated combinationally at capture:
  - Address 0: value is 0, never forwarded.
  - Otherwise, iMemRegWrite & iMemRdAddr match -> iMemData.
  - Otherwise, iWbRegWrite & iWbRdAddr match -> iWbData.
  - Otherwise, register-file data.
- Operand mapping: oDataA = fwd rs1; oDataB = iUseImm ? iImm : fwd rs2; oStoreData = fwd rs2.
- Flush: iFlush has priority over everything.
  - Next cycle: oValid=0, oRegWrite=0, oIsLoad=0, state EMPTY.
  - The incoming instruction is dropped; oReady may be 1 but nothing is captured.
  - Data registers need not clear.
- Reset asserted mid-operation: immediate return to reset values; no partial capture.
- Latency: 1 cycle from fire_in to oValid; 2 cycles when lu applies.

Optional Feature:
- Macro ALU_OPERAND_STALL_CNT_EN.
- Defined:
  - Adds port oStallCnt (out, 32) counting load-use bubble cycles.
  - Increments on entering BUBBLE; saturates at 0xFFFFFFFF.
  - Cleared by reset only; not cleared by flush.
- Undefined: no port and no counter logic.

Test Plan:
- Reset: iRstN=0 with iClk running -> oValid=0, oDataA=oDataB=0, oReady=1; release, then iValid=1, rs1=x5 (data 7), rs2=x6 (data 3), ADD -> next cycle oValid=1, oDataA=7, oDataB=3, oAluOp=0000.
- Forward priority: rs1=x3 with iMemRdAddr=3 / iMemData=0xAAAA and iWbRdAddr=3 / iWbData=0xBBBB, both writes enabled -> oDataA=0xAAAA; drop MEM write -> 0xBBBB; rs1=x0 with all matching on 0 -> oDataA=0.
- Load-use: LW x4 held, next instruction has rs1=x4, iReady=1 -> oReady=0 for 1 cycle, BUBBLE gives oValid=0; next cycle iMemRdAddr=4 / iMemData=0x1234 captured -> oDataA=0x1234.
- Backpressure: FULL with iReady=0 for 3 cycles while iValid=1 -> outputs stable, oReady=0; iReady=1 -> new entry loaded the following cycle.
- Flush: iFlush=1 in the same cycle as fire_in -> next cycle oValid=0, oRegWrite=0, and the instruction is not presented later.
- Immediate: iUseImm=1, iImm=0xFFFFFFF0, rs2 data=9 -> oDataB=0xFFFFFFF0, oStoreData=9; with ALU_OPERAND_STALL_CNT_EN, two load-use events -> oStallCnt=2.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers decoded instructions, forwards from MEM/WB, inserts a bubble on load-use.
// Optional load-use bubble counter (oStallCnt) enabled by defining ALU_OPERAND_STALL_CNT_EN.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int OP_W = 4
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iFlush,
  input  logic            iValid,
  output logic            oReady,
  input  logic [RA_W-1:0] iRs1Addr,
  input  logic [RA_W-1:0] iRs2Addr,
  input  logic [XLEN-1:0] iRs1Data,
  input  logic [XLEN-1:0] iRs2Data,
  input  logic [XLEN-1:0] iImm,
  input  logic            iUseImm,
  input  logic [OP_W-1:0] iAluOp,
  input  logic [RA_W-1:0] iRdAddr,
  input  logic            iRegWrite,
  input  logic            iIsLoad,
  input  logic [RA_W-1:0] iMemRdAddr,
  input  logic            iMemRegWrite,
  input  logic [XLEN-1:0] iMemData,
  input  logic [RA_W-1:0] iWbRdAddr,
  input  logic            iWbRegWrite,
  input  logic [XLEN-1:0] iWbData,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oDataA,
  output logic [XLEN-1:0] oDataB,
  output logic [XLEN-1:0] oStoreData,
  output logic [OP_W-1:0] oAluOp,
  output logic [RA_W-1:0] oRdAddr,
  output logic            oRegWrite,
  output logic            oIsLoad
`ifdef ALU_OPERAND_STALL_CNT_EN
  ,
  output logic [31:0]     oStallCnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] data_a_q, data_b_q, store_q;
  logic [OP_W-1:0] alu_op_q;
  logic [RA_W-1:0] rd_q;
  logic            regwrite_q, isload_q;

  logic            out_valid, lu, ready, fire_in, fire_out;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // MEM is younger than WB, so it wins when both target the same register.
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [RA_W-1:0] addr,
    input logic [XLEN-1:0] rf_data,
    input logic [RA_W-1:0] mem_rd,
    input logic            mem_we,
    input logic [XLEN-1:0] mem_data,
    input logic [RA_W-1:0] wb_rd,
    input logic            wb_we,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] val;
    if (addr == '0)                        val = '0;
    else if (mem_we && (mem_rd == addr))   val = mem_data;
    else if (wb_we && (wb_rd == addr))     val = wb_data;
    else                                   val = rf_data;
    return val;
  endfunction

  always_comb begin
    out_valid = (state_q == FULL);
    // Any rs2 match counts, so stores reading a just-loaded register also stall.
    lu = out_valid & isload_q & regwrite_q & (rd_q != '0) & iValid &
         ((rd_q == iRs1Addr) | (rd_q == iRs2Addr));
    ready    = ~lu & (~out_valid | iReady);
    fire_in  = iValid & ready;
    fire_out = out_valid & iReady;
    fwd_rs1  = fwd_operand(iRs1Addr, iRs1Data, iMemRdAddr, iMemRegWrite, iMemData,
                           iWbRdAddr, iWbRegWrite, iWbData);
    fwd_rs2  = fwd_operand(iRs2Addr, iRs2Data, iMemRdAddr, iMemRegWrite, iMemData,
                           iWbRdAddr, iWbRegWrite, iWbData);
  end

  always_comb begin
    state_d = state_q;
    if (iFlush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (fire_in) state_d = FULL;
        FULL: begin
          if (fire_out) begin
            if (fire_in)  state_d = FULL;
            else if (lu)  state_d = BUBBLE;
            else          state_d = EMPTY;
          end
        end
        BUBBLE:  state_d = fire_in ? FULL : EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q    <= EMPTY;
      data_a_q   <= '0;
      data_b_q   <= '0;
      store_q    <= '0;
      alu_op_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      isload_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (iFlush) begin
        regwrite_q <= 1'b0;
        isload_q   <= 1'b0;
      end else if (fire_in) begin
        data_a_q   <= fwd_rs1;
        data_b_q   <= iUseImm ? iImm : fwd_rs2;
        store_q    <= fwd_rs2;
        alu_op_q   <= iAluOp;
        rd_q       <= iRdAddr;
        regwrite_q <= iRegWrite;
        isload_q   <= iIsLoad;
      end
    end
  end

`ifdef ALU_OPERAND_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic        enter_bubble;

  assign enter_bubble = ~iFlush & fire_out & lu;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)                                  stall_cnt_q <= '0;
    else if (enter_bubble && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign oStallCnt = stall_cnt_q;
`endif

  assign oReady     = ready;
  assign oValid     = out_valid;
  assign oDataA     = data_a_q;
  assign oDataB     = data_b_q;
  assign oStoreData = store_q;
  assign oAluOp     = alu_op_q;
  assign oRdAddr    = rd_q;
  assign oRegWrite  = regwrite_q;
  assign oIsLoad    = isload_q;

endmodule
